// File: rtl/rv_uart_pkg.sv
// Shared definitions for the UART blocks: register offsets, STATUS layout, serializer states.
// Optional parity frame is enabled by RV_UART_TX_PARITY_EN (see rv_uart_tx_mmio).
package rv_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int unsigned ST_FULL   = 0;
  localparam int unsigned ST_EMPTY  = 1;
  localparam int unsigned ST_BUSY   = 2;
  localparam int unsigned ST_OVF    = 3;
  localparam int unsigned ST_COUNT  = 4;
  localparam int unsigned ST_PARITY = 31;

  localparam int unsigned DIV_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with occupancy count and a fall-through read port.
// Push is ignored when full, pop is ignored when empty.
module rv_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv_uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/BAUDDIV registers, TX FIFO and 8N1 serializer.
// Define RV_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module rv_uart_tx_mmio
  import rv_uart_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_WORD   = ADDR_WIDTH'(32'h4000),
  parameter int unsigned           FIFO_DEPTH  = 8,
  parameter logic [DIV_W-1:0]      DEFAULT_DIV = 16'd433
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  we,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  sel,
  output logic                  tx,
  output logic                  irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e        state;
  logic [DIV_W-1:0] baud_div;
  logic [DIV_W-1:0] timer;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             ovf;
`ifdef RV_UART_TX_PARITY_EN
  logic             par;
`endif

  logic [1:0]            idx;
  logic                  wr;
  logic                  push_c;
  logic                  pop_c;
  logic                  bit_end_c;
  logic [7:0]            fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] status_c;
  logic                  unused_bits;

  assign sel         = (d_addr[ADDR_WIDTH-1:2] == BASE_WORD[ADDR_WIDTH-1:2]);
  assign idx         = d_addr[1:0];
  assign wr          = en & we & sel;
  assign push_c      = wr & (idx == REG_TXDATA);
  assign bit_end_c   = (timer == '0);
  assign pop_c       = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end_c));
  assign irq         = fifo_empty & (state == S_IDLE);
  assign unused_bits = ^d_in[DATA_WIDTH-1:DIV_W];

  rv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (d_in[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // CSRs; a push to a full FIFO raises ovf even if a pop happens in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_div <= DEFAULT_DIV;
      ovf      <= 1'b0;
    end else begin
      if (push_c & fifo_full)                           ovf <= 1'b1;
      else if (wr & (idx == REG_STATUS) & d_in[ST_OVF]) ovf <= 1'b0;
      if (wr & (idx == REG_BAUDDIV)) baud_div <= d_in[DIV_W-1:0];
    end
  end

  always_comb begin
    status_c                    = '0;
    status_c[ST_FULL]           = fifo_full;
    status_c[ST_EMPTY]          = fifo_empty;
    status_c[ST_BUSY]           = (state != S_IDLE);
    status_c[ST_OVF]            = ovf;
    status_c[ST_COUNT +: CNT_W] = fifo_count;
`ifdef RV_UART_TX_PARITY_EN
    status_c[ST_PARITY]         = 1'b1;
`endif
  end

  always_comb begin
    d_out = '0;
    if (sel) begin
      case (idx)
        REG_STATUS:  d_out = status_c;
        REG_BAUDDIV: d_out = DATA_WIDTH'(baud_div);
        default:     d_out = '0;
      endcase
    end
  end

  // Serializer; the timer reloads from baud_div at every bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef RV_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop_c) begin
            shreg   <= fifo_rdata;
            bit_cnt <= 3'd7;
            timer   <= baud_div;
            tx      <= 1'b0;
            state   <= S_START;
`ifdef RV_UART_TX_PARITY_EN
            par     <= ^fifo_rdata;
`endif
          end
        end
        S_START: begin
          if (bit_end_c) begin
            state <= S_DATA;
            timer <= baud_div;
            tx    <= shreg[0];
          end else begin
            timer <= timer - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end_c) begin
            timer <= baud_div;
            if (bit_cnt == 3'd0) begin
`ifdef RV_UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= par;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_cnt <= bit_cnt - 3'd1;
            end
          end else begin
            timer <= timer - DIV_W'(1);
          end
        end
`ifdef RV_UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end_c) begin
            state <= S_STOP;
            timer <= baud_div;
            tx    <= 1'b1;
          end else begin
            timer <= timer - DIV_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end_c) begin
            if (pop_c) begin
              shreg   <= fifo_rdata;
              bit_cnt <= 3'd7;
              timer   <= baud_div;
              tx      <= 1'b0;
              state   <= S_START;
`ifdef RV_UART_TX_PARITY_EN
              par     <= ^fifo_rdata;
`endif
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            timer <= timer - DIV_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_uart_tx_mmio.sv
// Bench for rv_uart_tx_mmio: frame-level reference model compared every cycle, plus fixed scenarios.
module tb_rv_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h4000;
`ifdef RV_UART_TX_PARITY_EN
  localparam int          NB   = 11;
  localparam logic [31:0] PBIT = 32'h8000_0000;
`else
  localparam int          NB   = 10;
  localparam logic [31:0] PBIT = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, we, sel, tx, irq;
  logic [31:0] d_addr, d_in, d_out;

  always #5 clk = ~clk;

  rv_uart_tx_mmio dut (
    .clk    (clk),
    .rst    (rst),
    .d_addr (d_addr),
    .d_in   (d_in),
    .we     (we),
    .en     (en),
    .d_out  (d_out),
    .sel    (sel),
    .tx     (tx),
    .irq    (irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level model: byte queue plus the level list of the frame on the wire.
  logic [7:0]  m_q[$];
  bit          m_act  = 1'b0;
  int          m_b    = 0;
  int          m_left = 0;
  logic [10:0] m_bits = '1;
  logic        m_tx   = 1'b1;
  bit          m_ovf  = 1'b0;
  logic [15:0] m_div  = 16'd433;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s      = PBIT;
    s[0]   = (m_q.size() == 8);
    s[1]   = (m_q.size() == 0);
    s[2]   = m_act;
    s[3]   = m_ovf;
    s[7:4] = 4'(m_q.size());
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:2] != BASE[31:2]) return 32'h0;
    case (a[1:0])
      2'd1:    return m_status();
      2'd2:    return {16'h0, m_div};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    int         pre;
    bit         pop_now;
    bit         hit;
    logic [7:0] b;
    if (rst) begin
      m_q.delete();
      m_act = 1'b0;
      m_tx  = 1'b1;
      m_ovf = 1'b0;
      m_div = 16'd433;
      return;
    end
    pre     = m_q.size();
    pop_now = 1'b0;
    hit     = en && we && (d_addr[31:2] == BASE[31:2]);
    if (m_act) begin
      if (m_left > 0) m_left--;
      else begin
        m_b++;
        m_left = int'(m_div);
        if (m_b == NB) begin
          if (pre > 0) pop_now = 1'b1;
          else m_act = 1'b0;
        end
      end
    end else if (pre > 0) pop_now = 1'b1;
    if (pop_now) begin
      b = m_q.pop_front();
`ifdef RV_UART_TX_PARITY_EN
      m_bits = {1'b1, ^b, b, 1'b0};
`else
      m_bits = {1'b0, 1'b1, b, 1'b0};
`endif
      m_b    = 0;
      m_left = int'(m_div);
      m_act  = 1'b1;
    end
    if (hit && d_addr[1:0] == 2'd0) begin
      if (pre < 8) m_q.push_back(d_in[7:0]);
      else m_ovf = 1'b1;
    end
    if (hit && d_addr[1:0] == 2'd1 && d_in[3]) m_ovf = 1'b0;
    if (hit && d_addr[1:0] == 2'd2) m_div = d_in[15:0];
    m_tx = m_act ? m_bits[m_b] : 1'b1;
  endtask

  // One clock: check the combinational read port, advance model, check registered outputs.
  task automatic step();
    #1;
    chk("sel", 32'(sel), 32'(d_addr[31:2] == BASE[31:2]));
    chk("d_out", d_out, m_read(d_addr));
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("tx", 32'(tx), 32'(m_tx));
    chk("irq", 32'(irq), 32'(m_q.size() == 0 && !m_act));
  endtask

  task automatic idle_in();
    en     = 1'b0;
    we     = 1'b0;
    d_addr = 32'h0;
    d_in   = 32'h0;
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [31:0] data);
    en = 1'b1; we = 1'b1; d_addr = BASE + 32'(off); d_in = data;
    step();
    idle_in();
  endtask

  task automatic rd_reg(input logic [1:0] off, input string name, input logic [31:0] exp);
    en = 1'b1; we = 1'b0; d_addr = BASE + 32'(off); d_in = 32'h0;
    #1;
    chk(name, d_out, exp);
    step();
    idle_in();
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while ((m_q.size() != 0 || m_act) && k < max) begin
      step();
      k++;
    end
    chk("drain_irq", 32'(irq), 32'h1);
  endtask

  logic [NB-1:0] pat;
  logic [NB-1:0] smp;

  initial begin
    rst = 1'b1;
    idle_in();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Reset state
    rd_reg(2'd1, "t1_status", PBIT | 32'h2);
    rd_reg(2'd2, "t1_baud", 32'd433);
    chk("t1_tx", 32'(tx), 32'h1);
    chk("t1_irq", 32'(irq), 32'h1);

    // Single frame 0xA5, 4 clocks per bit
    wr_reg(2'd2, 32'd3);
    wr_reg(2'd0, 32'hA5);
    step();
`ifdef RV_UART_TX_PARITY_EN
    pat = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    pat = {1'b1, 8'hA5, 1'b0};
`endif
    for (int i = 0; i < NB * 4; i++) begin
      chk($sformatf("t2_tx[%0d]", i), 32'(tx), 32'(pat[i / 4]));
      step();
    end
    chk("t2_irq", 32'(irq), 32'h1);

    // Nine back-to-back stores at 2 clocks per bit
    wr_reg(2'd2, 32'd1);
    for (int i = 0; i < 9; i++) wr_reg(2'd0, 32'(i));
    rd_reg(2'd1, "t3_status", PBIT | 32'h85);
    wait_done(400);

    // Overflow and ovf clear
    wr_reg(2'd2, 32'd200);
    for (int i = 0; i < 10; i++) wr_reg(2'd0, 32'(8'h30 + i));
    rd_reg(2'd1, "t4_status_ovf", PBIT | 32'h8D);
    wr_reg(2'd1, 32'h8);
    rd_reg(2'd1, "t4_status_clr", PBIT | 32'h85);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_reg(2'd1, "t4_status_rst", PBIT | 32'h2);

    // Reset in the middle of data bit 3
    wr_reg(2'd2, 32'd3);
    wr_reg(2'd0, 32'h5A);
    wr_reg(2'd0, 32'h11);
    for (int k = 0; k < 100 && !(m_act && m_b == 4); k++) step();
    chk("t5_in_bit3", 32'(tx), 32'(1'b1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_tx", 32'(tx), 32'h1);
    chk("t5_irq", 32'(irq), 32'h1);
    rd_reg(2'd1, "t5_status", PBIT | 32'h2);
    repeat (30) step();

    // Disabled store and out-of-range address
    en = 1'b0; we = 1'b1; d_addr = BASE; d_in = 32'h77;
    step();
    idle_in();
    rd_reg(2'd1, "t6_status", PBIT | 32'h2);
    en = 1'b1; we = 1'b0; d_addr = BASE + 32'd4;
    #1;
    chk("t6_sel", 32'(sel), 32'h0);
    chk("t6_dout", d_out, 32'h0);
    step();
    idle_in();

`ifdef RV_UART_TX_PARITY_EN
    wr_reg(2'd2, 32'd0);
    wr_reg(2'd0, 32'h03);
    step();
    for (int i = 0; i < NB; i++) begin
      smp[i] = tx;
      step();
    end
    chk("par_bit", 32'(smp[9]), 32'h0);
    chk("par_stop", 32'(smp[10]), 32'h1);
    rd_reg(2'd1, "par_status", 32'h8000_0002);
`endif

    // Randomized traffic, light then heavy store rate
    for (int i = 0; i < 1500; i++) begin
      int r;
      int rate;
      r    = int'($urandom_range(0, 99));
      rate = (i < 750) ? 6 : 40;
      idle_in();
      if (r < rate) begin
        en = 1'b1; we = 1'b1; d_addr = BASE; d_in = $urandom;
      end else if (r < rate + 5) begin
        en = 1'b1; we = 1'b1; d_addr = BASE + 32'd2;
        d_in = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
      end else if (r < rate + 8) begin
        en = 1'b1; we = 1'b1; d_addr = BASE + 32'd1; d_in = $urandom;
      end else if (r < rate + 10) begin
        en = 1'b1; we = 1'b1; d_addr = BASE + 32'd3; d_in = $urandom;
      end else if (r < rate + 20) begin
        en = 1'($urandom_range(0, 1)); we = 1'b1;
        d_addr = $urandom | 32'h0001_0000; d_in = $urandom;
      end else if (r < rate + 25) begin
        en = 1'b0; we = 1'b1; d_addr = BASE; d_in = $urandom;
      end else begin
        en = 1'b1; we = 1'b0; d_addr = BASE + 32'($urandom_range(0, 3));
      end
      step();
    end
    idle_in();
    wait_done(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
